// File: rtl/q_shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : q_shift_pkg
//  Description : Shared definitions for the Q operand/quotient shift
//                register: default width and the shift-direction encoding.
//  Contents    : Q_WIDTH_DEFAULT  - default register width (8)
//                dir_e            - direction enum (DIR_RIGHT / DIR_LEFT)
//  Revision    : 1.0 - initial release
// ============================================================================
package q_shift_pkg;

  localparam int Q_WIDTH_DEFAULT = 8;

  // Direction encoding as driven on the dir pin by the ALU sequencer.
  typedef enum logic {
    DIR_RIGHT = 1'b0,   // toward LSB
    DIR_LEFT  = 1'b1    // toward MSB
  } dir_e;

endpackage : q_shift_pkg
`default_nettype wire

// File: rtl/q_shift_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : q_shift_reg_if
//  Description : Control/data bundle between the ALU sequencer (master) and
//                the Q shift register (slave).
//  Signals     : load - parallel load strobe (overrides dir)
//                dir  - shift direction, 0 = right, 1 = left
//                in   - parallel load data [WIDTH-1:0]
//                q    - register contents  [WIDTH-1:0]
//  Parameters  : WIDTH - register width, must be >= 2
//  Revision    : 1.0 - initial release
// ============================================================================
interface q_shift_reg_if
  import q_shift_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH_DEFAULT
);

  logic             load;
  logic             dir;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] q;

  // Sequencer side: drives the controls and data, observes q.
  modport master (
    output load,
    output dir,
    output in,
    input  q
  );

  // Register side.
  modport slave (
    input  load,
    input  dir,
    input  in,
    output q
  );

endinterface : q_shift_reg_if
`default_nettype wire

// File: rtl/q_shift_cell.sv
`default_nettype none
// ============================================================================
//  Module      : q_shift_cell
//  Description : One bit of the Q shift register. A direction mux picks the
//                MSB-side or LSB-side neighbour, a load mux picks that value
//                or the parallel data bit, and the result is captured in an
//                asynchronously reset D flip-flop.
//  Ports       : clk        - rising-edge clock
//                rst        - asynchronous active-high reset, clears the bit
//                load_i     - 1 = capture par_in_i (wins over dir_i)
//                dir_i      - 0 = take left_in_i, 1 = take right_in_i
//                left_in_i  - bit from the MSB-side neighbour (right shift)
//                right_in_i - bit from the LSB-side neighbour (left shift)
//                par_in_i   - parallel load data bit
//                q_o        - stored bit, straight from the flop
//  Revision    : 1.0 - initial release
// ============================================================================
module q_shift_cell
  import q_shift_pkg::*;
(
  input  wire  clk,
  input  wire  rst,
  input  wire  load_i,
  input  wire  dir_i,
  input  wire  left_in_i,
  input  wire  right_in_i,
  input  wire  par_in_i,
  output logic q_o
);

  logic shift_d;
  logic q_d;
  logic q_q;

  always_comb begin
    shift_d = left_in_i;
    q_d     = q_q;
    // A right shift pulls data down from the MSB side; a left shift pulls
    // data up from the LSB side.
    if (dir_e'(dir_i) == DIR_LEFT) begin
      shift_d = right_in_i;
    end
    q_d = load_i ? par_in_i : shift_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : q_shift_cell
`default_nettype wire

// File: rtl/q_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : q_shift_reg
//  Description : Parallel-load, bidirectional shift register holding the Q
//                operand/quotient word. Every rising edge it either loads
//                bus.in (load=1) or shifts one place in the direction given
//                by bus.dir; there is no hold state.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset, clears q
//                bus  - q_shift_reg_if.slave (load, dir, in, q)
//  Parameters  : WIDTH - register width, must be >= 2
//  Config      : Q_SHIFT_ROTATE_EN - when defined, shifts become rotates
//                (the bit leaving one end re-enters at the other); when
//                undefined, shifts are logical with a 0 fill.
//  Revision    : 1.0 - initial release
// ============================================================================
module q_shift_reg
  import q_shift_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH_DEFAULT
)(
  input  wire          clk,
  input  wire          rst,
  q_shift_reg_if.slave bus
);

  logic [WIDTH-1:0] q_w;         // cell outputs
  logic [WIDTH-1:0] left_nbr_w;  // per-bit MSB-side neighbour
  logic [WIDTH-1:0] right_nbr_w; // per-bit LSB-side neighbour
  logic             msb_fill_w;  // enters bit WIDTH-1 on a right shift
  logic             lsb_fill_w;  // enters bit 0 on a left shift

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("q_shift_reg: WIDTH must be at least 2");
    end
  endgenerate

`ifdef Q_SHIFT_ROTATE_EN
  // Rotate: the end bit about to be discarded wraps around.
  assign msb_fill_w = q_w[0];
  assign lsb_fill_w = q_w[WIDTH-1];
`else
  // Logical shift: zero fill, no sign extension.
  assign msb_fill_w = 1'b0;
  assign lsb_fill_w = 1'b0;
`endif

  // Neighbour vectors: bit i sees q[i+1] on its left and q[i-1] on its
  // right, with the end cells taking the fill/rotate bit instead.
  assign left_nbr_w  = {msb_fill_w, q_w[WIDTH-1:1]};
  assign right_nbr_w = {q_w[WIDTH-2:0], lsb_fill_w};

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      q_shift_cell u_cell (
        .clk        (clk),
        .rst        (rst),
        .load_i     (bus.load),
        .dir_i      (bus.dir),
        .left_in_i  (left_nbr_w[i]),
        .right_in_i (right_nbr_w[i]),
        .par_in_i   (bus.in[i]),
        .q_o        (q_w[i])
      );
    end
  endgenerate

  assign bus.q = q_w;

endmodule : q_shift_reg
`default_nettype wire

// File: tb/tb_q_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_q_shift_reg
//  Description : Directed, table-driven bench for q_shift_reg (WIDTH=8),
//                with hand-written sequences for asynchronous reset.
//                Expected values follow Q_SHIFT_ROTATE_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_q_shift_reg;

  localparam int W = 8;

  logic clk;
  logic rst;

  q_shift_reg_if #(.WIDTH(W)) bus ();

  q_shift_reg #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         load;
    logic         dir;
    logic [W-1:0] din;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

`ifdef Q_SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: q=%08b expected %08b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic load,
                              input logic dir, input logic [W-1:0] din,
                              input logic [W-1:0] exp);
    vec_t v;
    v.name = name; v.load = load; v.dir = dir; v.din = din; v.exp = exp;
    return v;
  endfunction

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic load, input logic dir, input logic [W-1:0] din);
    bus.load = load;
    bus.dir  = dir;
    bus.in   = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // -------- stimulus table: {name, load, dir, in, expected q} --------
    vecs.push_back(mk("load_b3",   1, 0, 8'hB3, 8'hB3));
    vecs.push_back(mk("shr1",      0, 0, 8'h00, ROT ? 8'hD9 : 8'h59));
    vecs.push_back(mk("shr2",      0, 0, 8'h00, ROT ? 8'hEC : 8'h2C));
    vecs.push_back(mk("shr3",      0, 0, 8'h00, ROT ? 8'h76 : 8'h16));
    vecs.push_back(mk("shr4",      0, 0, 8'h00, ROT ? 8'h3B : 8'h0B));
    vecs.push_back(mk("shl1",      0, 1, 8'h00, ROT ? 8'h76 : 8'h16));
    vecs.push_back(mk("shl2",      0, 1, 8'h00, ROT ? 8'hEC : 8'h2C));
    vecs.push_back(mk("shl3",      0, 1, 8'h00, ROT ? 8'hD9 : 8'h58));
    vecs.push_back(mk("shl4",      0, 1, 8'h00, ROT ? 8'hB3 : 8'hB0));
    vecs.push_back(mk("load_55",   1, 0, 8'h55, 8'h55));
    vecs.push_back(mk("mix_shl1",  0, 1, 8'h00, 8'hAA));
    vecs.push_back(mk("mix_shl2",  0, 1, 8'h00, 8'h55 ^ (ROT ? 8'h00 : 8'h01)));
    vecs.push_back(mk("mix_shl3",  0, 1, 8'h00, ROT ? 8'hAA : 8'hA8));
    vecs.push_back(mk("mix_shr1",  0, 0, 8'h00, ROT ? 8'h55 : 8'h54));
    vecs.push_back(mk("mix_shr2",  0, 0, 8'h00, ROT ? 8'hAA : 8'h2A));
    vecs.push_back(mk("load_0f",   1, 0, 8'h0F, 8'h0F));
    vecs.push_back(mk("load_prio", 1, 1, 8'hF0, 8'hF0));
    vecs.push_back(mk("load_01",   1, 1, 8'h01, 8'h01));
    vecs.push_back(mk("lsb_out",   0, 0, 8'h00, ROT ? 8'h80 : 8'h00));
    vecs.push_back(mk("load_80",   1, 0, 8'h80, 8'h80));
    vecs.push_back(mk("msb_out",   0, 1, 8'h00, ROT ? 8'h01 : 8'h00));
    vecs.push_back(mk("load_81",   1, 1, 8'h81, 8'h81));
    vecs.push_back(mk("ends_shr",  0, 0, 8'h00, ROT ? 8'hC0 : 8'h40));
    vecs.push_back(mk("ends_shl",  0, 1, 8'h00, ROT ? 8'h81 : 8'h80));
    vecs.push_back(mk("load_00",   1, 0, 8'h00, 8'h00));
    vecs.push_back(mk("zero_shr",  0, 0, 8'hFF, 8'h00));
    vecs.push_back(mk("zero_shl",  0, 1, 8'hFF, 8'h00));

    // -------- reset at time 0 --------
    rst      = 1'b1;
    bus.load = 1'b0;
    bus.dir  = 1'b0;
    bus.in   = '0;
    #1;
    check("reset_initial", bus.q, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 8'hFF);
    check("reset_release_shift", bus.q, 8'h00);

    // -------- table --------
    foreach (vecs[i]) begin
      step(vecs[i].load, vecs[i].dir, vecs[i].din);
      check(vecs[i].name, bus.q, vecs[i].exp);
    end

    // -------- async reset while holding a value, no clock edge --------
    step(1, 0, 8'hA5);
    check("pre_async_load", bus.q, 8'hA5);
    #2;
    rst = 1'b1;
    #1;                                  // still before the next edge
    check("async_clear", bus.q, 8'h00);

    // Reset held across an edge with a load pending: load is lost.
    bus.load = 1'b1;
    bus.in   = 8'hFF;
    @(posedge clk);
    #1;
    check("reset_beats_load", bus.q, 8'h00);
    rst = 1'b0;
    step(0, 1, 8'hFF);
    check("post_reset_shl_zero", bus.q, 8'h00);

    // -------- reset mid shift sequence --------
    step(1, 0, 8'hC3);
    check("mid_load", bus.q, 8'hC3);
    step(0, 0, 8'h00);
    check("mid_shr", bus.q, ROT ? 8'hE1 : 8'h61);
    #3;
    rst = 1'b1;
    #1;
    check("mid_async_clear", bus.q, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 8'h00);
    check("mid_after_release", bus.q, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time guard so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_q_shift_reg
`default_nettype wire
